// File: rtl/imm_ext_pkg.sv
// -----------------------------------------------------------------------------
// imm_ext_pkg
// Shared definitions for immediate extension. The decode unit and the
// extension unit both import this package, so they agree on the mode encoding.
//   mode_e  : extension mode (SEXT, ZEXT, LUI, BR)
//   IMM_W   : default raw immediate width
//   WORD_W  : default datapath word width
// -----------------------------------------------------------------------------
package imm_ext_pkg;

    typedef enum logic [1:0] {
        MODE_SEXT = 2'b00,
        MODE_ZEXT = 2'b01,
        MODE_LUI  = 2'b10,
        MODE_BR   = 2'b11
    } mode_e;

    localparam int IMM_W  = 16;
    localparam int WORD_W = 32;

endpackage

// File: rtl/imm_extend_unit_if.sv
// -----------------------------------------------------------------------------
// imm_extend_unit_if
// Handshake bundle between the instruction decode stage (master) and the
// immediate extension unit (slave).
//   in_valid/in_ready/in_imm/in_mode    : request side (decode -> unit)
//   out_valid/out_ready/out_data/out_ovf : result side (unit -> ALU operand mux)
// The master modport also drives out_ready on behalf of the consumer.
// -----------------------------------------------------------------------------
interface imm_extend_unit_if #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32
) ();
    logic             in_valid;
    logic             in_ready;
    logic [IN_W-1:0]  in_imm;
    logic [1:0]       in_mode;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] out_data;
    logic             out_ovf;

    modport master (
        output in_valid, in_imm, in_mode, out_ready,
        input  in_ready, out_valid, out_data, out_ovf
    );

    modport slave (
        input  in_valid, in_imm, in_mode, out_ready,
        output in_ready, out_valid, out_data, out_ovf
    );
endinterface

// File: rtl/imm_ext_core.sv
// -----------------------------------------------------------------------------
// imm_ext_core
// Purely combinational immediate extender.
//   i_imm  : raw IN_W-bit immediate
//   i_mode : extension mode (mode_e)
//   o_data : OUT_W-bit extended value
//   o_ovf  : set when the LUI shift pushed a nonzero bit past OUT_W
// -----------------------------------------------------------------------------
module imm_ext_core
    import imm_ext_pkg::*;
#(
    parameter int IN_W      = 16,
    parameter int OUT_W     = 32,
    parameter int LUI_SHIFT = 16,
    parameter int BR_SHIFT  = 2
) (
    input  logic [IN_W-1:0]  i_imm,
    input  mode_e            i_mode,
    output logic [OUT_W-1:0] o_data,
    output logic             o_ovf
);
    // Wide enough that the LUI shift never loses bits before we inspect them.
    localparam int WIDE_W = IN_W + LUI_SHIFT + OUT_W;

    logic [OUT_W-1:0]  w_sext;
    logic [OUT_W-1:0]  w_zext;
    logic [WIDE_W-1:0] w_lui_wide;

    assign w_sext     = OUT_W'($signed(i_imm));
    assign w_zext     = OUT_W'(i_imm);
    assign w_lui_wide = WIDE_W'(i_imm) << LUI_SHIFT;

    always_comb begin
        o_data = '0;
        o_ovf  = 1'b0;
        case (i_mode)
            MODE_SEXT: o_data = w_sext;
            MODE_ZEXT: o_data = w_zext;
            MODE_LUI: begin
                o_data = w_lui_wide[OUT_W-1:0];
                o_ovf  = |w_lui_wide[WIDE_W-1:OUT_W];
            end
            // OUT_W >= IN_W + BR_SHIFT, so only sign copies are shifted out.
            MODE_BR:   o_data = w_sext << BR_SHIFT;
            default:   o_data = '0;
        endcase
    end
endmodule

// File: rtl/imm_extend_unit.sv
// -----------------------------------------------------------------------------
// imm_extend_unit
// Buffered immediate extension: extends the incoming immediate and queues the
// result in a 2-entry in-order FIFO ahead of the ALU B-operand mux.
//   clk        : clock, all state on the rising edge
//   rst_n      : asynchronous active-low reset
//   flush      : synchronous flush; empties the FIFO, drops a concurrent push
//   bus        : request/result handshake (slave side)
//   accept_cnt : accepted-transfer count, saturating, cleared only by reset
// -----------------------------------------------------------------------------
module imm_extend_unit
    import imm_ext_pkg::*;
#(
    parameter int IN_W      = IMM_W,
    parameter int OUT_W     = WORD_W,
    parameter int LUI_SHIFT = 16,
    parameter int BR_SHIFT  = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                flush,
    imm_extend_unit_if.slave    bus,
    output logic [15:0]         accept_cnt
);
    logic [OUT_W-1:0] w_ext_data;
    logic             w_ext_ovf;
    logic             w_push;
    logic             w_pop;

    logic [OUT_W-1:0] r_data [2];
    logic             r_ovf  [2];
    logic             r_wr_ptr;
    logic             r_rd_ptr;
    logic [1:0]       r_count;
    logic [15:0]      r_accept_cnt;

    imm_ext_core #(
        .IN_W      (IN_W),
        .OUT_W     (OUT_W),
        .LUI_SHIFT (LUI_SHIFT),
        .BR_SHIFT  (BR_SHIFT)
    ) u_core (
        .i_imm  (bus.in_imm),
        .i_mode (mode_e'(bus.in_mode)),
        .o_data (w_ext_data),
        .o_ovf  (w_ext_ovf)
    );

    // in_ready comes only from the registered count: no path from out_ready.
    assign bus.in_ready  = (r_count != 2'd2);
    assign bus.out_valid = (r_count != 2'd0);
    assign bus.out_data  = r_data[r_rd_ptr];
    assign bus.out_ovf   = r_ovf[r_rd_ptr];
    assign accept_cnt    = r_accept_cnt;

    // A flush cycle neither stores nor retires anything.
    assign w_push = bus.in_valid  && bus.in_ready  && !flush;
    assign w_pop  = bus.out_valid && bus.out_ready && !flush;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_entry
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_data[gi] <= '0;
                    r_ovf[gi]  <= 1'b0;
                end else if (w_push && (r_wr_ptr == 1'(gi))) begin
                    r_data[gi] <= w_ext_data;
                    r_ovf[gi]  <= w_ext_ovf;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else if (flush) begin
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_accept_cnt <= 16'd0;
        end else if (w_push && (r_accept_cnt != 16'hFFFF)) begin
            r_accept_cnt <= r_accept_cnt + 16'd1;
        end
    end
endmodule

// File: tb/tb_imm_extend_unit.sv
module tb_imm_extend_unit;
    import imm_ext_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        flush24;
    logic [15:0] accept_cnt;
    logic [15:0] accept_cnt24;

    imm_extend_unit_if #(.IN_W(16), .OUT_W(32)) u_if ();
    imm_extend_unit_if #(.IN_W(16), .OUT_W(24)) u_if24 ();

    imm_extend_unit u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .bus        (u_if),
        .accept_cnt (accept_cnt)
    );

    imm_extend_unit #(.IN_W(16), .OUT_W(24), .LUI_SHIFT(16), .BR_SHIFT(2)) u_dut24 (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush24),
        .bus        (u_if24),
        .accept_cnt (accept_cnt24)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    int          vectors = 0;
    int          miscompares = 0;
    int          exp_cnt = 0;
    logic [32:0] sb_q [$];
    logic [32:0] cur_exp;
    logic        last_fire;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_in(input logic v, input logic [15:0] imm, input mode_e mode,
                          input logic ovf, input logic [31:0] data);
        u_if.in_valid = v;
        u_if.in_imm   = imm;
        u_if.in_mode  = mode;
        cur_exp       = {ovf, data};
    endtask

    // One cycle: compare against the scoreboard mid-cycle, update it, cross the edge.
    task automatic tick();
        int sz;
        @(negedge clk);
        sz = sb_q.size();
        check("out_valid", 64'(u_if.out_valid), 64'(sz != 0));
        check("in_ready", 64'(u_if.in_ready), 64'(sz < 2));
        check("accept_cnt", 64'(accept_cnt), 64'(exp_cnt));
        if (sz != 0) check("head", 64'({u_if.out_ovf, u_if.out_data}), 64'(sb_q[0]));
        last_fire = 1'b0;
        if (flush) begin
            sb_q.delete();
        end else begin
            if (sz != 0 && u_if.out_ready) void'(sb_q.pop_front());
            if (u_if.in_valid && sz < 2) begin
                sb_q.push_back(cur_exp);
                last_fire = 1'b1;
                if (exp_cnt != 16'hFFFF) exp_cnt++;
            end
        end
        $display("t=%0t in_v=%0b imm=%h mode=%0d out_rdy=%0b flush=%0b fire=%0b out_v=%0b out=%h cnt=%0d",
                 $time, u_if.in_valid, u_if.in_imm, u_if.in_mode, u_if.out_ready, flush,
                 last_fire, u_if.out_valid, u_if.out_data, accept_cnt);
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        flush = 1'b0;
        flush24 = 1'b0;
        u_if.out_ready = 1'b0;
        u_if24.out_ready = 1'b0;
        u_if24.in_valid = 1'b0;
        u_if24.in_imm = '0;
        u_if24.in_mode = MODE_SEXT;
        set_in(1'b0, 16'h0000, MODE_SEXT, 1'b0, 32'h0);
        #3;
        check("rst_out_valid", 64'(u_if.out_valid), 64'(0));
        check("rst_in_ready", 64'(u_if.in_ready), 64'(1));
        check("rst_out_data", 64'(u_if.out_data), 64'(0));
        check("rst_out_ovf", 64'(u_if.out_ovf), 64'(0));
        check("rst_accept_cnt", 64'(accept_cnt), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Each extension mode, streaming with out_ready=1.
        u_if.out_ready = 1'b1;
        set_in(1'b1, 16'hFFFF, MODE_SEXT, 1'b0, 32'hFFFFFFFF); tick();
        set_in(1'b1, 16'h7FFF, MODE_SEXT, 1'b0, 32'h00007FFF); tick();
        set_in(1'b1, 16'hFFFF, MODE_ZEXT, 1'b0, 32'h0000FFFF); tick();
        set_in(1'b1, 16'h1234, MODE_LUI,  1'b0, 32'h12340000); tick();
        set_in(1'b1, 16'hFFFE, MODE_BR,   1'b0, 32'hFFFFFFF8); tick();
        set_in(1'b1, 16'h0003, MODE_BR,   1'b0, 32'h0000000C); tick();
        set_in(1'b0, 16'h0000, MODE_SEXT, 1'b0, 32'h0); tick();
        tick();

        // Backpressure: three back-to-back pushes with the consumer stalled.
        u_if.out_ready = 1'b0;
        set_in(1'b1, 16'h0001, MODE_ZEXT, 1'b0, 32'h00000001); tick();
        set_in(1'b1, 16'h0002, MODE_ZEXT, 1'b0, 32'h00000002); tick();
        set_in(1'b1, 16'h0003, MODE_ZEXT, 1'b0, 32'h00000003); tick(); tick();
        u_if.out_ready = 1'b1;
        tick();
        tick();
        set_in(1'b0, 16'h0000, MODE_SEXT, 1'b0, 32'h0); tick();
        tick();

        // Flush at count=2 with a concurrent request.
        u_if.out_ready = 1'b0;
        set_in(1'b1, 16'h00AA, MODE_ZEXT, 1'b0, 32'h000000AA); tick();
        set_in(1'b1, 16'h00BB, MODE_ZEXT, 1'b0, 32'h000000BB); tick();
        flush = 1'b1; u_if.out_ready = 1'b1;
        set_in(1'b1, 16'h00CC, MODE_ZEXT, 1'b0, 32'h000000CC); tick();
        flush = 1'b0;
        set_in(1'b0, 16'h0000, MODE_SEXT, 1'b0, 32'h0); tick();

        // Flush at count=1 where in_ready=1: the push must be dropped.
        u_if.out_ready = 1'b0;
        set_in(1'b1, 16'h8000, MODE_SEXT, 1'b0, 32'hFFFF8000); tick();
        flush = 1'b1;
        set_in(1'b1, 16'h0011, MODE_ZEXT, 1'b0, 32'h00000011); tick();
        flush = 1'b0;
        set_in(1'b0, 16'h0000, MODE_SEXT, 1'b0, 32'h0); tick();

        // Asynchronous reset with two entries buffered.
        set_in(1'b1, 16'h0055, MODE_ZEXT, 1'b0, 32'h00000055); tick();
        set_in(1'b1, 16'h0066, MODE_ZEXT, 1'b0, 32'h00000066); tick();
        set_in(1'b0, 16'h0000, MODE_SEXT, 1'b0, 32'h0);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_out_valid", 64'(u_if.out_valid), 64'(0));
        check("arst_in_ready", 64'(u_if.in_ready), 64'(1));
        check("arst_accept_cnt", 64'(accept_cnt), 64'(0));
        check("arst_out_data", 64'(u_if.out_data), 64'(0));
        check("arst_out_ovf", 64'(u_if.out_ovf), 64'(0));
        sb_q.delete();
        exp_cnt = 0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        u_if.out_ready = 1'b1;
        set_in(1'b1, 16'h0100, MODE_LUI, 1'b0, 32'h01000000); tick();
        set_in(1'b0, 16'h0000, MODE_SEXT, 1'b0, 32'h0); tick();
        tick();

        // 24-bit output instance: LUI overflow detection.
        u_if24.out_ready = 1'b1;
        u_if24.in_valid = 1'b1; u_if24.in_imm = 16'h0100; u_if24.in_mode = MODE_LUI;
        @(posedge clk); #1;
        u_if24.in_imm = 16'h00AB;
        @(negedge clk);
        check("w24_lui_ovf_valid", 64'(u_if24.out_valid), 64'(1));
        check("w24_lui_ovf_data", 64'(u_if24.out_data), 64'(24'h000000));
        check("w24_lui_ovf_flag", 64'(u_if24.out_ovf), 64'(1));
        @(posedge clk); #1;
        u_if24.in_imm = 16'h8001; u_if24.in_mode = MODE_SEXT;
        @(negedge clk);
        check("w24_lui_data", 64'(u_if24.out_data), 64'(24'hAB0000));
        check("w24_lui_flag", 64'(u_if24.out_ovf), 64'(0));
        @(posedge clk); #1;
        u_if24.in_valid = 1'b0;
        @(negedge clk);
        check("w24_sext_data", 64'(u_if24.out_data), 64'(24'hFF8001));
        check("w24_sext_flag", 64'(u_if24.out_ovf), 64'(0));
        @(posedge clk); #1;
        @(negedge clk);
        check("w24_drained", 64'(u_if24.out_valid), 64'(0));
        check("w24_accept_cnt", 64'(accept_cnt24), 64'(3));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
